// File: rtl/button_decoder_if.sv
// Button decoder signal bundle: raw buttons in, decoded events/levels/count out.
interface button_decoder_if;
   logic       btn1;
   logic       btn2;
   logic       btn1_evt;
   logic       btn2_evt;
   logic       btn1_held;
   logic       btn2_held;
   logic [5:0] count;
   logic [5:0] led;

   // Driver side (board / bench) pushes buttons and observes results.
   modport master (
      output btn1, btn2,
      input  btn1_evt, btn2_evt, btn1_held, btn2_held, count, led
   );

   // Decoder side.
   modport slave (
      input  btn1, btn2,
      output btn1_evt, btn2_evt, btn1_held, btn2_held, count, led
   );
endinterface

// File: rtl/button_decoder.sv
// Two-button decoder: synchronize, debounce, hold/auto-repeat, and drive an
// up/down 6-bit count with active-low LED mirror.
module button_decoder #(
   parameter int unsigned DEBOUNCE_CYCLES = 32'd270000,
   parameter int unsigned HOLD_CYCLES     = 32'd13500000,
   parameter int unsigned REPEAT_CYCLES   = 32'd2700000
) (
   input  logic             clk,
   input  logic             rst_n,
   button_decoder_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      REPEAT,
      RELEASE_WAIT
   } state_e;

   logic [1:0] btn_raw;
   logic [1:0] evt_w;
   logic [1:0] held_w;

   // Index 0 is the increment button, index 1 the decrement button.
   assign btn_raw = {bus.btn2, bus.btn1};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_btn
         logic        sync1_q;
         logic        sync2_q;
         state_e      state_q, state_d;
         state_e      prev_q, prev_d;
         logic [31:0] stab_q, stab_d;
         logic [31:0] tmr_q, tmr_d;
         logic        evt_q, evt_d;
         logic        held_q, held_d;

         // Two-flop synchronizer for the raw asynchronous pin.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync1_q <= 1'b0;
               sync2_q <= 1'b0;
            end else begin
               sync1_q <= btn_raw[gi];
               sync2_q <= sync1_q;
            end
         end

         // FSM state, counters and registered outputs.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state_q <= IDLE;
               prev_q  <= HELD;
               stab_q  <= 32'd0;
               tmr_q   <= 32'd0;
               evt_q   <= 1'b0;
               held_q  <= 1'b0;
            end else begin
               state_q <= state_d;
               prev_q  <= prev_d;
               stab_q  <= stab_d;
               tmr_q   <= tmr_d;
               evt_q   <= evt_d;
               held_q  <= held_d;
            end
         end

         // Next-state logic. The cycle that leaves IDLE (or HELD/REPEAT)
         // already counts as the first stable cycle, hence the +2 tests.
         // tmr is shared by HELD (hold time) and REPEAT (repeat period) and
         // is left untouched while bouncing through RELEASE_WAIT.
         always_comb begin
            state_d = state_q;
            prev_d  = prev_q;
            stab_d  = stab_q;
            tmr_d   = tmr_q;
            evt_d   = 1'b0;
            held_d  = held_q;
            case (state_q)
               IDLE: begin
                  held_d = 1'b0;
                  tmr_d  = 32'd0;
                  if (sync2_q) begin
                     stab_d = 32'd0;
                     if (DEBOUNCE_CYCLES <= 32'd1) begin
                        state_d = HELD;
                        held_d  = 1'b1;
                        evt_d   = 1'b1;
                     end else begin
                        state_d = PRESS_WAIT;
                     end
                  end
               end
               PRESS_WAIT: begin
                  if (!sync2_q) begin
                     state_d = IDLE;
                  end else if (stab_q + 32'd2 >= DEBOUNCE_CYCLES) begin
                     state_d = HELD;
                     held_d  = 1'b1;
                     evt_d   = 1'b1;
                     tmr_d   = 32'd0;
                  end else begin
                     stab_d = stab_q + 32'd1;
                  end
               end
               HELD, REPEAT: begin
                  if (!sync2_q) begin
                     prev_d = state_q;
                     stab_d = 32'd0;
                     if (DEBOUNCE_CYCLES <= 32'd1) begin
                        state_d = IDLE;
                        held_d  = 1'b0;
                        tmr_d   = 32'd0;
                     end else begin
                        state_d = RELEASE_WAIT;
                     end
                  end else if (tmr_q + 32'd1 >=
                               ((state_q == HELD) ? HOLD_CYCLES : REPEAT_CYCLES)) begin
                     state_d = REPEAT;
                     evt_d   = 1'b1;
                     tmr_d   = 32'd0;
                  end else begin
                     tmr_d = tmr_q + 32'd1;
                  end
               end
               RELEASE_WAIT: begin
                  if (sync2_q) begin
                     state_d = prev_q;
                  end else if (stab_q + 32'd2 >= DEBOUNCE_CYCLES) begin
                     state_d = IDLE;
                     held_d  = 1'b0;
                     tmr_d   = 32'd0;
                  end else begin
                     stab_d = stab_q + 32'd1;
                  end
               end
               default: begin
                  state_d = IDLE;
               end
            endcase
         end

         assign evt_w[gi]  = evt_q;
         assign held_w[gi] = held_q;
      end
   endgenerate

   logic [5:0] count_q, count_d;

   // Count follows the event pulses one cycle later; a tie clears it.
   always_comb begin
      count_d = count_q;
      case (evt_w)
         2'b01:   count_d = count_q + 6'd1;
         2'b10:   count_d = count_q - 6'd1;
         2'b11:   count_d = 6'd0;
         default: count_d = count_q;
      endcase
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 6'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign bus.btn1_evt  = evt_w[0];
   assign bus.btn2_evt  = evt_w[1];
   assign bus.btn1_held = held_w[0];
   assign bus.btn2_held = held_w[1];
   assign bus.count     = count_q;
   assign bus.led       = ~count_q;

endmodule
